// File: rtl/can_pkg.sv
// Shared CAN controller types: frame field widths, transmit scheduler states and the mailbox record.
package can_pkg;

  localparam int unsigned CAN_EXT_ID_W = 29;
  localparam int unsigned CAN_DLC_W    = 4;
  localparam int unsigned CAN_DATA_W   = 64;
  localparam int unsigned RETRY_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_END,
    ST_EVAL,
    ST_RETIRE
  } state_e;

  typedef struct packed {
    logic [CAN_EXT_ID_W-1:0] id;
    logic [CAN_DLC_W-1:0]    dlc;
    logic [CAN_DATA_W-1:0]   data;
  } mbox_t;

endpackage

// File: rtl/can_prio_select.sv
// Combinational minimum-ID finder over a valid mask; equal IDs resolve to the lowest index.
module can_prio_select
  import can_pkg::*;
#(
  parameter int unsigned NUM_MBOX = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned ID_W     = CAN_EXT_ID_W
) (
  input  logic [NUM_MBOX-1:0]      valid_i,
  input  logic [NUM_MBOX*ID_W-1:0] ids_i,
  output logic [IDX_W-1:0]         sel_idx_c,
  output logic                     any_valid_c
);

  logic [ID_W-1:0] best_id;

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_id     = '1;
    sel_idx_c   = '0;
    any_valid_c = 1'b0;
    for (int i = 0; i < int'(NUM_MBOX); i++) begin
      if (valid_i[i] && (!any_valid_c || (ids_i[i*ID_W +: ID_W] < best_id))) begin
        any_valid_c = 1'b1;
        best_id     = ids_i[i*ID_W +: ID_W];
        sel_idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Multi-mailbox CAN transmit scheduler: offers the lowest-ID pending frame to the TX engine,
// handles the start/busy handshake, arbitration-loss requeue, ACK retries, aborts and completion.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int unsigned NUM_MBOX      = 4,
  parameter int unsigned IDX_W         = 2,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [CAN_EXT_ID_W-1:0] wr_id_i,
  input  logic [CAN_DLC_W-1:0]    wr_dlc_i,
  input  logic [CAN_DATA_W-1:0]   wr_data_i,
  input  logic [NUM_MBOX-1:0]     abort_i,
  output logic [NUM_MBOX-1:0]     pending_o,
  output logic                    done_o,
  output logic [IDX_W-1:0]        done_idx_o,
  output logic                    done_ok_o,
  output logic                    tx_start_o,
  output logic [CAN_EXT_ID_W-1:0] tx_id_o,
  output logic [CAN_DLC_W-1:0]    tx_dlc_o,
  output logic [CAN_DATA_W-1:0]   tx_data_o,
  input  logic                    tx_busy_i,
  input  logic                    tx_lost_i,
  input  logic                    tx_ack_i,
  output logic                    busy_o
);

  localparam int unsigned TO_W = $clog2(START_TIMEOUT) + 1;

  mbox_t                   mbox_q [NUM_MBOX];
  mbox_t                   mbox_d [NUM_MBOX];
  logic [RETRY_W-1:0]      retry_q [NUM_MBOX];
  logic [RETRY_W-1:0]      retry_d [NUM_MBOX];
  logic [NUM_MBOX-1:0]     pending_q, pending_d;
  logic [NUM_MBOX-1:0]     abort_pend_q, abort_pend_d;
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        act_idx_q, act_idx_d;
  logic                    ack_q, ack_d;
  logic                    lost_q, lost_d;
  logic                    act_abort_q, act_abort_d;
  logic [TO_W-1:0]         cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic [IDX_W-1:0]        done_idx_q, done_idx_d;
  logic                    done_ok_q, done_ok_d;
  logic                    tx_start_q, tx_start_d;
  logic [CAN_EXT_ID_W-1:0] tx_id_q, tx_id_d;
  logic [CAN_DLC_W-1:0]    tx_dlc_q, tx_dlc_d;
  logic [CAN_DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                    busy_q, busy_d;

  logic [NUM_MBOX-1:0]              active_mask;
  logic [NUM_MBOX-1:0]              new_abort;
  logic [NUM_MBOX-1:0]              sel_valid;
  logic [NUM_MBOX*CAN_EXT_ID_W-1:0] ids_flat;
  logic [IDX_W-1:0]                 sel_idx;
  logic                             sel_any;
  logic                             retire;
  logic                             retire_ok;
  logic                             abort_act;
  logic                             found;

  // The mailbox owned by the FSM from START through RETIRE is excluded from writes and selection.
  always_comb begin
    active_mask = '0;
    if (state_q != ST_IDLE) begin
      active_mask[act_idx_q] = 1'b1;
    end
    new_abort = abort_i & pending_q & ~active_mask;
    sel_valid = pending_q & ~active_mask & ~abort_i;
    for (int i = 0; i < int'(NUM_MBOX); i++) begin
      ids_flat[i*CAN_EXT_ID_W +: CAN_EXT_ID_W] = mbox_q[i].id;
    end
  end

  can_prio_select #(
    .NUM_MBOX (NUM_MBOX),
    .IDX_W    (IDX_W),
    .ID_W     (CAN_EXT_ID_W)
  ) u_prio_select (
    .valid_i     (sel_valid),
    .ids_i       (ids_flat),
    .sel_idx_c   (sel_idx),
    .any_valid_c (sel_any)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_MBOX); i++) begin
      mbox_d[i]  = mbox_q[i];
      retry_d[i] = retry_q[i];
    end
    pending_d    = pending_q & ~new_abort;
    abort_pend_d = abort_pend_q | new_abort;
    state_d      = state_q;
    act_idx_d    = act_idx_q;
    ack_d        = ack_q;
    lost_d       = lost_q;
    act_abort_d  = act_abort_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    done_idx_d   = '0;
    done_ok_d    = 1'b0;
    tx_start_d   = tx_start_q;
    tx_id_d      = tx_id_q;
    tx_dlc_d     = tx_dlc_q;
    tx_data_d    = tx_data_q;
    retire       = 1'b0;
    retire_ok    = 1'b0;
    abort_act    = act_abort_q | abort_i[act_idx_q];
    found        = 1'b0;

    if (wr_en_i && (int'(wr_idx_i) < int'(NUM_MBOX)) && !active_mask[wr_idx_i]) begin
      mbox_d[wr_idx_i]    = '{id: wr_id_i, dlc: wr_dlc_i, data: wr_data_i};
      pending_d[wr_idx_i] = 1'b1;
      retry_d[wr_idx_i]   = '0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          act_idx_d   = sel_idx;
          tx_id_d     = mbox_q[sel_idx].id;
          tx_dlc_d    = mbox_q[sel_idx].dlc;
          tx_data_d   = mbox_q[sel_idx].data;
          tx_start_d  = 1'b1;
          cnt_d       = '0;
          ack_d       = 1'b0;
          lost_d      = 1'b0;
          act_abort_d = 1'b0;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        ack_d       = ack_q | tx_ack_i;
        lost_d      = lost_q | tx_lost_i;
        act_abort_d = abort_act;
        if (tx_busy_i) begin
          tx_start_d = 1'b0;
          state_d    = ST_WAIT_END;
        end else if (cnt_q + TO_W'(1) == TO_W'(START_TIMEOUT)) begin
          tx_start_d = 1'b0;
          retire     = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      ST_WAIT_END: begin
        ack_d       = ack_q | tx_ack_i;
        lost_d      = lost_q | tx_lost_i;
        act_abort_d = abort_act;
        if (!tx_busy_i) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // ACK beats a pending abort or loss; an abort beats requeue and retry.
        if (ack_q) begin
          retire    = 1'b1;
          retire_ok = 1'b1;
        end else if (abort_act) begin
          retire = 1'b1;
        end else if (lost_q) begin
          state_d = ST_IDLE;
        end else if (retry_q[act_idx_q] < RETRY_W'(MAX_RETRY)) begin
          retry_d[act_idx_q] = retry_q[act_idx_q] + RETRY_W'(1);
          state_d            = ST_IDLE;
        end else begin
          retire = 1'b1;
        end
      end
      ST_RETIRE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (retire) begin
      state_d              = ST_RETIRE;
      done_d               = 1'b1;
      done_idx_d           = act_idx_q;
      done_ok_d            = retire_ok;
      pending_d[act_idx_q] = 1'b0;
      retry_d[act_idx_q]   = '0;
    end

    // Abort completions use the done slot only when the FSM is not retiring this cycle.
    if (!done_d) begin
      for (int i = 0; i < int'(NUM_MBOX); i++) begin
        if (!found && abort_pend_d[i]) begin
          found           = 1'b1;
          done_d          = 1'b1;
          done_idx_d      = IDX_W'(i);
          done_ok_d       = 1'b0;
          abort_pend_d[i] = 1'b0;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_MBOX); i++) begin
        mbox_q[i]  <= '0;
        retry_q[i] <= '0;
      end
      pending_q    <= '0;
      abort_pend_q <= '0;
      state_q      <= ST_IDLE;
      act_idx_q    <= '0;
      ack_q        <= 1'b0;
      lost_q       <= 1'b0;
      act_abort_q  <= 1'b0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      done_idx_q   <= '0;
      done_ok_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_id_q      <= '0;
      tx_dlc_q     <= '0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_MBOX); i++) begin
        mbox_q[i]  <= mbox_d[i];
        retry_q[i] <= retry_d[i];
      end
      pending_q    <= pending_d;
      abort_pend_q <= abort_pend_d;
      state_q      <= state_d;
      act_idx_q    <= act_idx_d;
      ack_q        <= ack_d;
      lost_q       <= lost_d;
      act_abort_q  <= act_abort_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      done_idx_q   <= done_idx_d;
      done_ok_q    <= done_ok_d;
      tx_start_q   <= tx_start_d;
      tx_id_q      <= tx_id_d;
      tx_dlc_q     <= tx_dlc_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
    end
  end

  assign pending_o  = pending_q;
  assign done_o     = done_q;
  assign done_idx_o = done_idx_q;
  assign done_ok_o  = done_ok_q;
  assign tx_start_o = tx_start_q;
  assign tx_id_o    = tx_id_q;
  assign tx_dlc_o   = tx_dlc_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: priority selection vectors plus multi-cycle handshake sequences.
module tb_can_tx_scheduler;
  import can_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [28:0] wr_id = '0;
  logic [3:0]  wr_dlc = '0;
  logic [63:0] wr_data = '0;
  logic [3:0]  abort = '0;
  logic [3:0]  pending_o;
  logic        done_o;
  logic [1:0]  done_idx_o;
  logic        done_ok_o;
  logic        tx_start_o;
  logic [28:0] tx_id_o;
  logic [3:0]  tx_dlc_o;
  logic [63:0] tx_data_o;
  logic        tx_busy = 1'b0;
  logic        tx_lost = 1'b0;
  logic        tx_ack = 1'b0;
  logic        busy_o;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned done_cnt = 0;
  int unsigned start_cnt = 0;
  logic        start_prev = 1'b0;

  always #5 clk = ~clk;

  can_tx_scheduler #(
    .NUM_MBOX      (4),
    .IDX_W         (2),
    .MAX_RETRY     (3),
    .START_TIMEOUT (64)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_id_i    (wr_id),
    .wr_dlc_i   (wr_dlc),
    .wr_data_i  (wr_data),
    .abort_i    (abort),
    .pending_o  (pending_o),
    .done_o     (done_o),
    .done_idx_o (done_idx_o),
    .done_ok_o  (done_ok_o),
    .tx_start_o (tx_start_o),
    .tx_id_o    (tx_id_o),
    .tx_dlc_o   (tx_dlc_o),
    .tx_data_o  (tx_data_o),
    .tx_busy_i  (tx_busy),
    .tx_lost_i  (tx_lost),
    .tx_ack_i   (tx_ack),
    .busy_o     (busy_o)
  );

  always @(negedge clk) begin
    if (done_o) done_cnt = done_cnt + 1;
    if (tx_start_o && !start_prev) start_cnt = start_cnt + 1;
    start_prev = tx_start_o;
  end

  typedef struct packed {
    logic [3:0]        load;
    logic [3:0][28:0]  ids;
    logic [1:0]        exp_idx;
    logic [28:0]       exp_id;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input logic [3:0] load, input logic [28:0] i3, input logic [28:0] i2,
                              input logic [28:0] i1, input logic [28:0] i0,
                              input logic [1:0] eidx, input logic [28:0] eid);
    vec_t v;
    v.load    = load;
    v.ids     = {i3, i2, i1, i0};
    v.exp_idx = eidx;
    v.exp_id  = eid;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_id = '0; wr_dlc = '0; wr_data = '0;
    abort = '0; tx_busy = 1'b0; tx_lost = 1'b0; tx_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [28:0] id);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_id = id; wr_dlc = id[3:0]; wr_data = {35'h1234, id};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_start(output bit started);
    started = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_start_o) begin
        started = 1'b1;
        break;
      end
    end
    if (!started) chk("start_wait_expired", 64'(started), 64'd1);
  endtask

  // Engine model: accept the start, stay busy four cycles, pulse ack/lost in the middle.
  task automatic engine(input bit ack, input bit lost, output logic [28:0] id_seen,
                        output logic [63:0] data_seen);
    bit started;
    id_seen = '0;
    data_seen = '0;
    wait_start(started);
    if (!started) return;
    id_seen = tx_id_o;
    data_seen = tx_data_o;
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    tx_ack = ack; tx_lost = lost;
    @(negedge clk);
    tx_ack = 1'b0; tx_lost = 1'b0;
    @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic expect_done(input string nm, input logic [1:0] eidx, input bit eok,
                             input logic [3:0] epend);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, "_idx"}, 64'(done_idx_o), 64'(eidx));
      chk({nm, "_ok"}, 64'(done_ok_o), 64'(eok));
      chk({nm, "_pending"}, 64'(pending_o), 64'(epend));
    end
  endtask

  logic [28:0] id_s;
  logic [63:0] data_s;
  bit          st;
  int unsigned s0, d0, cnt;

  initial begin
    vecs[0] = mk(4'b0101, 29'h0,        29'h050,        29'h0,   29'h100, 2'd2, 29'h050);
    vecs[1] = mk(4'b1111, 29'h400,      29'h100,        29'h200, 29'h300, 2'd2, 29'h100);
    vecs[2] = mk(4'b0110, 29'h0,        29'h0AB,        29'h0AB, 29'h0,   2'd1, 29'h0AB);
    vecs[3] = mk(4'b1000, 29'h1FFFFFFF, 29'h0,          29'h0,   29'h0,   2'd3, 29'h1FFFFFFF);
    vecs[4] = mk(4'b1011, 29'h0,        29'h0,          29'h1,   29'h0,   2'd0, 29'h0);
    vecs[5] = mk(4'b1100, 29'h12345677, 29'h12345678,   29'h0,   29'h0,   2'd3, 29'h12345677);

    do_reset;
    @(negedge clk);
    chk("reset_pending", 64'(pending_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_start", 64'(tx_start_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);

    // Selection vectors: the first-loaded frame loses arbitration, then the minimum ID goes out.
    for (int v = 0; v < 6; v++) begin
      do_reset;
      for (int m = 0; m < 4; m++) begin
        if (vecs[v].load[m]) wr(2'(m), vecs[v].ids[m]);
      end
      engine(1'b0, 1'b1, id_s, data_s);
      engine(1'b1, 1'b0, id_s, data_s);
      chk($sformatf("vec%0d_id", v), 64'(id_s), 64'(vecs[v].exp_id));
      expect_done($sformatf("vec%0d_done", v), vecs[v].exp_idx, 1'b1,
                  vecs[v].load & ~(4'b0001 << vecs[v].exp_idx));
    end

    // Two frames acked in priority order.
    do_reset;
    wr(2'd2, 29'h050);
    wr(2'd0, 29'h100);
    chk("order_pending0", 64'(pending_o), 64'h5);
    engine(1'b1, 1'b0, id_s, data_s);
    chk("order_id0", 64'(id_s), 64'h050);
    chk("order_data0", data_s, {35'h1234, 29'h050});
    expect_done("order_a", 2'd2, 1'b1, 4'b0001);
    engine(1'b1, 1'b0, id_s, data_s);
    chk("order_id1", 64'(id_s), 64'h100);
    expect_done("order_b", 2'd0, 1'b1, 4'b0000);

    // Three arbitration losses then ACK.
    do_reset;
    s0 = start_cnt; d0 = done_cnt;
    wr(2'd0, 29'h123);
    repeat (3) engine(1'b0, 1'b1, id_s, data_s);
    engine(1'b1, 1'b0, id_s, data_s);
    expect_done("loss", 2'd0, 1'b1, 4'b0000);
    repeat (3) @(negedge clk);
    chk("loss_starts", 64'(start_cnt - s0), 64'd4);
    chk("loss_dones", 64'(done_cnt - d0), 64'd1);

    // No ACK ever: initial attempt plus three retries, then failure.
    do_reset;
    s0 = start_cnt;
    wr(2'd1, 29'h0AA);
    repeat (4) engine(1'b0, 1'b0, id_s, data_s);
    expect_done("noack", 2'd1, 1'b0, 4'b0000);
    repeat (5) @(negedge clk);
    chk("noack_starts", 64'(start_cnt - s0), 64'd4);
    chk("noack_busy", 64'(busy_o), 64'd0);

    // Higher-priority frame written while the active frame is on the bus and then loses.
    do_reset;
    wr(2'd1, 29'h200);
    wait_start(st);
    tx_busy = 1'b1;
    wr(2'd3, 29'h010);
    tx_lost = 1'b1;
    @(negedge clk);
    tx_lost = 1'b0; tx_busy = 1'b0;
    engine(1'b1, 1'b0, id_s, data_s);
    chk("preempt_id0", 64'(id_s), 64'h010);
    expect_done("preempt_a", 2'd3, 1'b1, 4'b0010);
    engine(1'b1, 1'b0, id_s, data_s);
    chk("preempt_id1", 64'(id_s), 64'h200);
    expect_done("preempt_b", 2'd1, 1'b1, 4'b0000);

    // Engine never goes busy: start held for the full timeout.
    do_reset;
    wr(2'd0, 29'h007);
    wait_start(st);
    cnt = st ? 1 : 0;
    for (int c = 0; c < 200 && st; c++) begin
      @(negedge clk);
      if (tx_start_o) cnt = cnt + 1;
      else break;
    end
    chk("timeout_cycles", 64'(cnt), 64'd64);
    chk("timeout_done", 64'(done_o), 64'd1);
    chk("timeout_idx", 64'(done_idx_o), 64'd0);
    chk("timeout_ok", 64'(done_ok_o), 64'd0);
    @(negedge clk);
    chk("timeout_busy", 64'(busy_o), 64'd0);

    // Abort of a pending, non-active mailbox reports on the next cycle.
    do_reset;
    wr(2'd0, 29'h010);
    wr(2'd1, 29'h020);
    @(negedge clk);
    abort = 4'b0010;
    @(negedge clk);
    abort = '0;
    chk("abort_done", 64'(done_o), 64'd1);
    chk("abort_idx", 64'(done_idx_o), 64'd1);
    chk("abort_ok", 64'(done_ok_o), 64'd0);
    chk("abort_pending", 64'(pending_o), 64'h1);
    engine(1'b1, 1'b0, id_s, data_s);
    expect_done("abort_rest", 2'd0, 1'b1, 4'b0000);

    // Abort arriving while the FSM retires: abort completion follows one cycle later.
    do_reset;
    wr(2'd0, 29'h010);
    wr(2'd1, 29'h020);
    engine(1'b1, 1'b0, id_s, data_s);
    @(negedge clk);
    abort = 4'b0010;
    @(negedge clk);
    abort = '0;
    chk("coll_done0", 64'(done_o), 64'd1);
    chk("coll_idx0", 64'(done_idx_o), 64'd0);
    chk("coll_ok0", 64'(done_ok_o), 64'd1);
    @(negedge clk);
    chk("coll_done1", 64'(done_o), 64'd1);
    chk("coll_idx1", 64'(done_idx_o), 64'd1);
    chk("coll_ok1", 64'(done_ok_o), 64'd0);
    chk("coll_pending", 64'(pending_o), 64'd0);

    // Abort of the active frame lands at evaluation; the frame finishes on the bus first.
    do_reset;
    wr(2'd2, 29'h030);
    wait_start(st);
    tx_busy = 1'b1;
    @(negedge clk);
    abort = 4'b0100;
    @(negedge clk);
    abort = '0; tx_lost = 1'b1;
    @(negedge clk);
    tx_lost = 1'b0; tx_busy = 1'b0;
    expect_done("abort_act", 2'd2, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    chk("abort_act_busy", 64'(busy_o), 64'd0);

    // Reset mid-frame clears everything at once, with no completion pulse.
    do_reset;
    wr(2'd0, 29'h040);
    wait_start(st);
    tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_pending", 64'(pending_o), 64'd0);
    chk("midrst_txid", 64'(tx_id_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_idle", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Parametrised multi-mailbox transmit scheduler for the CAN controller. Replaces the fixed single-frame register set and one-shot start sequencing in the current top level.
- Holds NUM_MBOX extended-format frames and always offers the pending frame with the lowest 29-bit ID (CAN priority) to the bit-level TX engine.
- Handles the start/busy handshake with the engine, re-queues on arbitration loss, retries unacknowledged frames up to MAX_RETRY, and reports per-mailbox completion.

Parameters:
- NUM_MBOX, 4, number of transmit mailboxes (2..16)
- IDX_W, 2, mailbox index width, equal to clog2(NUM_MBOX)
- MAX_RETRY, 3, maximum number of retransmissions after missing ACK (0..15)
- START_TIMEOUT, 64, cycles to wait for tx_busy_i after tx_start_o is raised

Ports:
- clk_i  in  1  CAN clock domain; the single clock of the block
- rst_i  in  1  asynchronous, active-high reset
- wr_en_i  in  1  load a mailbox this cycle
- wr_idx_i  in  IDX_W  target mailbox
- wr_id_i  in  29  extended identifier
- wr_dlc_i  in  4  data length code
- wr_data_i  in  64  payload
- abort_i  in  NUM_MBOX  per-mailbox cancel request
- pending_o  out  NUM_MBOX  mailbox loaded and not yet retired
- done_o  out  1  one-cycle retire pulse
- done_idx_o  out  IDX_W  mailbox retired
- done_ok_o  out  1  1 = acknowledged; 0 = failed or aborted
- tx_start_o  out  1  start request to the TX engine
- tx_id_o  out  29  frame fields presented to the engine
- tx_dlc_o  out  4  frame fields presented to the engine
- tx_data_o  out  64  frame fields presented to the engine
- tx_busy_i  in  1  engine busy
- tx_lost_i  in  1  arbitration-lost pulse from the engine
- tx_ack_i  in  1  acknowledged pulse from the engine
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (async, immediate): all mailboxes empty; all outputs 0; retry counters 0; FSM in IDLE. Reset asserted mid-frame drops everything, with no done_o pulse.
- Write: on wr_en_i, mailbox wr_idx_i is loaded and its pending bit is set on the next edge.
  - Writing a pending, inactive mailbox overwrites it and clears its retry count.
  - Writing the active mailbox (one between START and RETIRE) is ignored.
- Selection: combinational. Pick the minimum ID among pending, non-active mailboxes; equal IDs resolve to the lowest index.
- FSM states:
  - IDLE: if any mailbox is pending, latch the selected index as active, drive tx_* from it, go to START. Decision latency is 1 cycle.
  - START: tx_start_o=1 and the timeout counter runs.
    - tx_busy_i=1 -> WAIT_END, tx_start_o=0.
    - Counter reaches START_TIMEOUT -> RETIRE with fail.
  - WAIT_END: sticky-latch tx_ack_i and tx_lost_i. On the cycle tx_busy_i falls, go to EVAL.
  - EVAL:
    - ack -> RETIRE ok.
    - lost -> IDLE with the mailbox still pending; the retry count is not incremented (arbitration loss is not an error).
    - Neither, with retry < MAX_RETRY -> retry+1, then IDLE.
    - Otherwise -> RETIRE fail.
    - If ack and lost are both latched, ack wins.
  - RETIRE: done_o=1 for one cycle with done_idx_o/done_ok_o; clear pending and retry for that mailbox; go to IDLE.
- Re-selection after a loss or retry goes through IDLE, so a newly written higher-priority frame can pre-empt the old one.
- Abort:
  - abort_i on a pending, non-active mailbox clears it immediately and emits done_o with ok=0. If this collides with a RETIRE pulse in the same cycle, the abort pulse is deferred one cycle; the abort mask is held until served.
  - abort_i on the active mailbox takes effect only at EVAL: fail unless ack was latched. An in-flight frame is never truncated.
- tx_id_o/tx_dlc_o/tx_data_o hold stable from START until the next IDLE exit.
- The START timeout counter is clog2(START_TIMEOUT)+1 bits, saturating.
- The retry counter is 4 bits per mailbox.

Decomposition:
- can_pkg holds:
  - state enum (IDLE, START, WAIT_END, EVAL, RETIRE)
  - CAN_EXT_ID_W=29, CAN_DLC_W=4, CAN_DATA_W=64
  - mailbox record typedef {id, dlc, data}
- Sub-module can_prio_select: parametrised NUM_MBOX min-ID finder taking valid mask and IDs, returning index plus any_valid. It is purely combinational and reused by the RX filter later.

Test Plan:
- Load mbox0 id=0x100 and mbox2 id=0x050; engine acks each frame -> mbox2 is sent first; done pulses (2,ok=1) then (0,ok=1); pending_o goes 0101 -> 0001 -> 0000.
- Single frame, engine pulses tx_lost_i 3 times, then acks -> 4 tx_start_o assertions; retry count stays 0; one done with ok=1.
- MAX_RETRY=3, engine never acks -> exactly 4 attempts, then done ok=0.
- While mbox1 id=0x200 is in WAIT_END and loses arbitration, write mbox3 id=0x010 -> next start carries 0x010.
- tx_busy_i held 0 -> tx_start_o high for 64 cycles, then done ok=0 and busy_o drops.
- Pulse abort_i[1] on a pending mailbox -> done (1,ok=0) next cycle. Assert rst_i mid WAIT_END -> all outputs 0 immediately; no done pulse.
